// File: rtl/sudoku_pkg.sv
// Shared types for the 9x9 candidate-grid scanner and its iteration sequencer.
//   cell_t      : 9-bit candidate mask for one cell
//   grid_t      : row-major grid, g[row][col]
//   boxgrid_t   : box-major grid, b[box_row][box_col][k]
//   seq_state_e : sequencer FSM states
package sudoku_pkg;

  localparam int NUM_CELLS = 81;

  typedef logic [8:0] cell_t;
  typedef cell_t [8:0][8:0] grid_t;
  typedef cell_t [2:0][2:0][8:0] boxgrid_t;

  typedef enum logic [1:0] {
    IDLE,
    SCAN_RST,
    SETTLE,
    EVAL
  } seq_state_e;

endpackage

// File: rtl/box_to_row_map.sv
// Purely combinational remap of a box-major scanner grid to row-major order.
// Ports:
//   box_i  : boxgrid_t, element [bi][bj][k]
//   grid_o : grid_t, element [row][col]
// Within a box, k walks down a column first: row = 3*bi + k%3, col = 3*bj + k/3.
module box_to_row_map
  import sudoku_pkg::*;
(
  input  boxgrid_t box_i,
  output grid_t    grid_o
);

  for (genvar gbi = 0; gbi < 3; gbi++) begin : g_bi
    for (genvar gbj = 0; gbj < 3; gbj++) begin : g_bj
      for (genvar gk = 0; gk < 9; gk++) begin : g_k
        assign grid_o[3*gbi + gk%3][3*gbj + gk/3] = box_i[gbi][gbj][gk];
      end
    end
  end

endmodule

// File: rtl/scan_sequencer.sv
// Iteration controller for the 9x9 candidate-grid scanner. Holds the working
// grid, runs the scanner (reset, settle, sample) and writes its result back
// until the scanner reports complete, the grid stops changing, or the
// iteration cap is reached.
// Ports:
//   i_Clk, i_Reset_n          : clock, asynchronous active-low reset
//   i_Load_Valid/Idx/Cell     : host cell write (IDLE only, idx 0..80)
//   i_Start                   : begin a run (IDLE only)
//   o_Busy, o_Done            : not-IDLE level, one-cycle end-of-run pulse
//   o_Solved/Stuck/Timeout    : run status, held until the next accepted start
//   i_Rd_Idx, o_Rd_Cell       : registered readback of one cell
//   o_Scan_Grid, o_Scan_Reset : working grid and active-high reset to scanner
//   i_Scan_Grid, i_Scan_Complete : scanner result (box-major) and complete flag
// Optional build macro SCAN_SEQ_STATS_EN adds o_Iter_Count and o_Cycle_Count.
module scan_sequencer
  import sudoku_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4,
  parameter int MAX_ITERS     = 64
) (
  input  logic       i_Clk,
  input  logic       i_Reset_n,
  input  logic       i_Load_Valid,
  input  logic [6:0] i_Load_Idx,
  input  cell_t      i_Load_Cell,
  input  logic       i_Start,
  output logic       o_Busy,
  output logic       o_Done,
  output logic       o_Solved,
  output logic       o_Stuck,
  output logic       o_Timeout,
  input  logic [6:0] i_Rd_Idx,
  output cell_t      o_Rd_Cell,
  output grid_t      o_Scan_Grid,
  output logic       o_Scan_Reset,
  input  boxgrid_t   i_Scan_Grid,
  input  logic       i_Scan_Complete
`ifdef SCAN_SEQ_STATS_EN
  ,
  output logic [7:0]  o_Iter_Count,
  output logic [15:0] o_Cycle_Count
`endif
);

  localparam logic [6:0] LAST_IDX    = 7'(NUM_CELLS - 1);
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
  localparam logic [7:0] ITER_CAP    = 8'(MAX_ITERS);

  seq_state_e            state_q, state_d;
  logic [3:0]            settle_q, settle_d;
  logic [7:0]            iter_q, iter_d;
  cell_t [NUM_CELLS-1:0] cells_q, cells_d;
  logic                  solved_q, solved_d;
  logic                  stuck_q, stuck_d;
  logic                  timeout_q, timeout_d;
  logic                  done_q, done_d;
  cell_t                 rd_cell_q;

  grid_t                 next_grid;
  cell_t [NUM_CELLS-1:0] next_cells;
  logic [7:0]            iter_inc;

  box_to_row_map u_map (
    .box_i  (i_Scan_Grid),
    .grid_o (next_grid)
  );

  // Flat view: cell index row*9+col lines up with the row-major packed layout.
  assign next_cells = next_grid;
  assign iter_inc   = iter_q + 8'd1;

  always_comb begin
    state_d   = state_q;
    settle_d  = settle_q;
    iter_d    = iter_q;
    cells_d   = cells_q;
    solved_d  = solved_q;
    stuck_d   = stuck_q;
    timeout_d = timeout_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        // Load is applied in the same cycle a start is accepted.
        if (i_Load_Valid && (i_Load_Idx <= LAST_IDX)) begin
          cells_d[i_Load_Idx] = i_Load_Cell;
        end
        if (i_Start) begin
          state_d   = SCAN_RST;
          iter_d    = '0;
          solved_d  = 1'b0;
          stuck_d   = 1'b0;
          timeout_d = 1'b0;
        end
      end
      SCAN_RST: begin
        settle_d = '0;
        state_d  = SETTLE;
      end
      SETTLE: begin
        if (settle_q == SETTLE_LAST) begin
          state_d = EVAL;
        end else begin
          settle_d = settle_q + 4'd1;
        end
      end
      EVAL: begin
        if (i_Scan_Complete) begin
          cells_d  = next_cells;
          solved_d = 1'b1;
          done_d   = 1'b1;
          state_d  = IDLE;
        end else if (next_cells == cells_q) begin
          stuck_d  = 1'b1;
          done_d   = 1'b1;
          state_d  = IDLE;
        end else if (iter_inc == ITER_CAP) begin
          cells_d   = next_cells;
          timeout_d = 1'b1;
          done_d    = 1'b1;
          state_d   = IDLE;
        end else begin
          cells_d = next_cells;
          iter_d  = iter_inc;
          state_d = SCAN_RST;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state_q   <= IDLE;
      settle_q  <= '0;
      iter_q    <= '0;
      cells_q   <= '0;
      solved_q  <= 1'b0;
      stuck_q   <= 1'b0;
      timeout_q <= 1'b0;
      done_q    <= 1'b0;
      rd_cell_q <= '0;
    end else begin
      state_q   <= state_d;
      settle_q  <= settle_d;
      iter_q    <= iter_d;
      cells_q   <= cells_d;
      solved_q  <= solved_d;
      stuck_q   <= stuck_d;
      timeout_q <= timeout_d;
      done_q    <= done_d;
      rd_cell_q <= (i_Rd_Idx <= LAST_IDX) ? cells_q[i_Rd_Idx] : '0;
    end
  end

  assign o_Busy       = (state_q != IDLE);
  // Scanner runs only while settling and while its result is sampled.
  assign o_Scan_Reset = (state_q == IDLE) || (state_q == SCAN_RST);
  assign o_Done       = done_q;
  assign o_Solved     = solved_q;
  assign o_Stuck      = stuck_q;
  assign o_Timeout    = timeout_q;
  assign o_Rd_Cell    = rd_cell_q;
  assign o_Scan_Grid  = cells_q;

`ifdef SCAN_SEQ_STATS_EN
  logic        start_ok;
  logic [7:0]  iter_cnt_q, iter_cnt_d;
  logic [15:0] cycle_q, cycle_d;

  assign start_ok = (state_q == IDLE) && i_Start;

  always_comb begin
    iter_cnt_d = iter_cnt_q;
    cycle_d    = cycle_q;
    if (start_ok) begin
      iter_cnt_d = '0;
      cycle_d    = '0;
    end else begin
      // Number of EVAL passes in the run that just ended.
      if (done_d) begin
        iter_cnt_d = iter_inc;
      end
      if (o_Busy && (cycle_q != 16'hFFFF)) begin
        cycle_d = cycle_q + 16'd1;
      end
    end
  end

  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      iter_cnt_q <= '0;
      cycle_q    <= '0;
    end else begin
      iter_cnt_q <= iter_cnt_d;
      cycle_q    <= cycle_d;
    end
  end

  assign o_Iter_Count  = iter_cnt_q;
  assign o_Cycle_Count = cycle_q;
`endif

endmodule

// File: tb/tb_scan_sequencer.sv
// Directed bench for scan_sequencer (SETTLE_CYCLES=4, MAX_ITERS=3).
// A small scanner model drives a box-major result; in "vary" mode box
// element [0][0][0] follows the count of scanner reset pulses so every pass
// changes one cell.
module tb_scan_sequencer;
  import sudoku_pkg::*;

  localparam int PER = 6;  // SETTLE_CYCLES + 2

  logic       clk = 1'b0;
  logic       rst_n;
  logic       load_valid;
  logic [6:0] load_idx;
  cell_t      load_cell;
  logic       start;
  logic       busy, done, solved, stuck, timeout;
  logic [6:0] rd_idx;
  cell_t      rd_cell;
  grid_t      scan_grid;
  logic       scan_reset;
  boxgrid_t   scan_box;
  logic       scan_complete;
`ifdef SCAN_SEQ_STATS_EN
  logic [7:0]  iter_count;
  logic [15:0] cycle_count;
`endif

  boxgrid_t static_box;
  logic     vary;
  int       complete_at;
  int       pass_cnt = 0;
  int       cyc = 0;
  int       cyc0;
  int       base;
  int       saw;
  int       total = 0;
  int       bad = 0;
  grid_t    exp_grid;

  always #5 clk = ~clk;

  scan_sequencer #(.SETTLE_CYCLES(4), .MAX_ITERS(3)) dut (
    .i_Clk           (clk),
    .i_Reset_n       (rst_n),
    .i_Load_Valid    (load_valid),
    .i_Load_Idx      (load_idx),
    .i_Load_Cell     (load_cell),
    .i_Start         (start),
    .o_Busy          (busy),
    .o_Done          (done),
    .o_Solved        (solved),
    .o_Stuck         (stuck),
    .o_Timeout       (timeout),
    .i_Rd_Idx        (rd_idx),
    .o_Rd_Cell       (rd_cell),
    .o_Scan_Grid     (scan_grid),
    .o_Scan_Reset    (scan_reset),
    .i_Scan_Grid     (scan_box),
    .i_Scan_Complete (scan_complete)
`ifdef SCAN_SEQ_STATS_EN
    ,
    .o_Iter_Count    (iter_count),
    .o_Cycle_Count   (cycle_count)
`endif
  );

  // Count scanner reset pulses issued during a run (one per pass).
  always @(posedge clk) begin
    if (busy && scan_reset) pass_cnt <= pass_cnt + 1;
  end

  always_comb begin
    scan_box = static_box;
    if (vary) scan_box[0][0][0] = {1'b1, pass_cnt[7:0]};
    scan_complete = (complete_at != 0) && (pass_cnt == complete_at);
  end

  function automatic cell_t fv(input int p);
    return {1'b1, p[7:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_grid(input string tag, input grid_t exp);
    total++;
    assert (scan_grid === exp)
    else begin
      bad++;
      $error("FAIL %s: got %h expected %h", tag, scan_grid, exp);
    end
  endtask

  task automatic wait_done(input int limit);
    for (int i = 0; i < limit; i++) begin
      tick();
      if (done) break;
    end
  endtask

  task automatic do_start();
    base  = pass_cnt;
    start = 1'b1;
    tick();
    cyc0  = cyc;
    start = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; load_valid = 1'b0; load_idx = '0; load_cell = '0;
    start = 1'b0; rd_idx = '0;
    static_box = '0; vary = 1'b0; complete_at = 0; exp_grid = '0;
    tick(); tick();

    // Reset state
    chk("rst_busy", busy, 0);
    chk("rst_scan_reset", scan_reset, 1);
    chk("rst_flags", {done, solved, stuck, timeout}, 0);
    chk("rst_rd", rd_cell, 0);
    chk_grid("rst_grid", exp_grid);
    rst_n = 1'b1;
    tick();

    // Load idx 40, attempt out-of-range idx 81, read back
    load_valid = 1'b1; load_idx = 7'd40; load_cell = 9'h010;
    tick();
    load_idx = 7'd81; load_cell = 9'h1AA;
    tick();
    load_valid = 1'b0; rd_idx = 7'd40;
    #1;
    chk("rd_latency", rd_cell, 0);
    tick();
    chk("rd_idx40", rd_cell, 9'h010);
    chk("grid_4_4", scan_grid[4][4], 9'h010);
    exp_grid[4][4] = 9'h010;
    chk_grid("grid_after_load", exp_grid);
    rd_idx = 7'd81;
    tick();
    chk("rd_oob", rd_cell, 0);

    // Stuck: scanner echoes the grid; load idx 0 in the same cycle as start
    static_box[0][0][0] = 9'h001;
    static_box[1][1][4] = 9'h010;
    load_valid = 1'b1; load_idx = 7'd0; load_cell = 9'h001;
    do_start();
    load_valid = 1'b0;
    chk("stuck_busy", busy, 1);
    wait_done(40);
    chk("stuck_latency", cyc - cyc0, PER);
    chk("stuck_flags", {solved, stuck, timeout}, 3'b010);
    chk("stuck_passes", pass_cnt - base, 1);
    exp_grid[0][0] = 9'h001;
    chk_grid("stuck_grid", exp_grid);
    tick();
    chk("stuck_idle", {busy, done}, 0);

    // Solve on the 3rd pass (also the cap pass: complete has priority)
    vary = 1'b1;
    complete_at = pass_cnt + 3;
    do_start();
    chk("start_clears_stuck", stuck, 0);
    wait_done(60);
    chk("solve_latency", cyc - cyc0, 3 * PER);
    chk("solve_flags", {solved, stuck, timeout}, 3'b100);
    chk("solve_passes", pass_cnt - base, 3);
    exp_grid[0][0] = fv(base + 3);
    chk_grid("solve_grid", exp_grid);
    tick();
    chk("done_one_cycle", done, 0);

    // Timeout: every pass changes a cell, never complete
    complete_at = 0;
    do_start();
    wait_done(60);
    chk("timeout_latency", cyc - cyc0, 3 * PER);
    chk("timeout_flags", {solved, stuck, timeout}, 3'b001);
    chk("timeout_passes", pass_cnt - base, 3);
    exp_grid[0][0] = fv(base + 3);
    chk_grid("timeout_grid", exp_grid);
`ifdef SCAN_SEQ_STATS_EN
    chk("stats_iter", iter_count, 3);
    chk("stats_cycles", cycle_count, 3 * PER);
`endif

    // Busy rules: load and start during SETTLE are ignored
    vary = 1'b0;
    load_valid = 1'b1; load_idx = 7'd0; load_cell = 9'h001;
    tick();
    load_valid = 1'b0;
    exp_grid[0][0] = 9'h001;
    do_start();
    chk("scan_rst_high", scan_reset, 1);
    tick();
    chk("settle_scan_reset", scan_reset, 0);
    load_valid = 1'b1; load_idx = 7'd0; load_cell = 9'h0AA; start = 1'b1;
    tick();
    load_valid = 1'b0; start = 1'b0;
    wait_done(40);
    chk("busy_latency", cyc - cyc0, PER);
    chk("busy_flags", {solved, stuck, timeout}, 3'b010);
    chk("busy_passes", pass_cnt - base, 1);
    chk_grid("busy_grid", exp_grid);

    // Mapping: distinct box elements land in hand-computed cells
    static_box[1][2][5] = 9'h1FF;  // -> g[5][7]
    static_box[2][1][4] = 9'h0F0;  // -> g[7][4]
    static_box[0][2][8] = 9'h003;  // -> g[2][8]
    complete_at = pass_cnt + 1;
    do_start();
    wait_done(40);
    chk("map_latency", cyc - cyc0, PER);
    chk("map_flags", {solved, stuck, timeout}, 3'b100);
    chk("map_g57", scan_grid[5][7], 9'h1FF);
    exp_grid[5][7] = 9'h1FF;
    exp_grid[7][4] = 9'h0F0;
    exp_grid[2][8] = 9'h003;
    chk_grid("map_grid", exp_grid);
    rd_idx = 7'd52;
    tick();
    chk("map_rd52", rd_cell, 9'h1FF);

    // Reset mid-SETTLE aborts the run
    complete_at = 0;
    do_start();
    tick(); tick(); tick();
    chk("pre_rst_busy", {busy, scan_reset}, 2'b10);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_scan_reset", scan_reset, 1);
    chk("mid_rst_flags", {done, solved, stuck, timeout}, 0);
    exp_grid = '0;
    chk_grid("mid_rst_grid", exp_grid);
    tick();
    rst_n = 1'b1;
    rd_idx = 7'd40;
    tick();
    chk("mid_rst_rd", rd_cell, 0);
    saw = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (done || busy) saw++;
    end
    chk("no_done_after_rst", saw, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
